// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory request, next-PC
// selection, a one-entry pending-redirect buffer and the fetch/decode latch.

package fetch_stage_pkg;

    typedef enum logic [1:0] {
        PIPE_ENABLE = 2'd0,
        PIPE_STALL  = 2'd1,
        PIPE_NOP    = 2'd2
    } pipe_state_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         ihit,
    input  logic [31:0]  imemload,
    output logic         imemREN,
    output logic [31:0]  imemaddr,
    input  logic         pc_wen,
    input  logic [1:0]   pcsrc,
    input  logic [31:0]  br_target,
    input  logic [31:0]  jr_target,
    input  logic [31:0]  j_target,
    input  pipe_state_t  fd_state,
    input  logic         halt,
    output logic [31:0]  fd_instr,
    output logic [31:0]  fd_pcplus4,
    output logic         fd_valid,
    output logic         redirect_pending,
    output fetch_state_t fsm_state
);

    // Instruction memory handshake: imemREN is the request and stays high for
    // as long as the stage runs; ihit marks imemload as valid in that cycle.
    // There is no back-pressure, so a word without ihit simply becomes a bubble.

    fetch_state_t state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [31:0] fd_instr_q, fd_instr_d;
    logic [31:0] fd_pcplus4_q, fd_pcplus4_d;
    logic        fd_valid_q, fd_valid_d;

    logic [31:0] pcplus4;
    logic        redirect_req;
    logic [31:0] redirect_target;
    logic        take_pending;

    assign pcplus4      = pc_q + 32'd4;
    assign redirect_req = (pcsrc != 2'd0);

    always_comb begin
        redirect_target = pcplus4;
        case (pcsrc)
            2'd1:    redirect_target = br_target;
            2'd2:    redirect_target = jr_target;
            2'd3:    redirect_target = j_target;
            default: redirect_target = pcplus4;
        endcase
    end

    // A stored redirect is only consumed when no fresher redirect competes.
    assign take_pending = (state_q == RUN) && !halt && pc_wen
                          && !redirect_req && pend_valid_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        fd_instr_d    = fd_instr_q;
        fd_pcplus4_d  = fd_pcplus4_q;
        fd_valid_d    = fd_valid_q;

        case (state_q)
            RUN: begin
                if (halt) begin
                    state_d = HALTED;
                end else begin
                    if (pc_wen && redirect_req) begin
                        pc_d         = redirect_target;
                        pend_valid_d = 1'b0;
                    end else if (take_pending) begin
                        pc_d         = pend_target_q;
                        pend_valid_d = 1'b0;
                    end else if (pc_wen) begin
                        pc_d = pcplus4;
                    end else if (redirect_req) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = redirect_target;
                    end

                    // The word fetched at the old PC is wrong-path once the
                    // pending target is applied.
                    if (take_pending) begin
                        fd_instr_d   = 32'd0;
                        fd_pcplus4_d = 32'd0;
                        fd_valid_d   = 1'b0;
                    end else begin
                        case (fd_state)
                            PIPE_ENABLE: begin
                                if (ihit) begin
                                    fd_instr_d   = imemload;
                                    fd_pcplus4_d = pcplus4;
                                    fd_valid_d   = 1'b1;
                                end else begin
                                    fd_instr_d   = 32'd0;
                                    fd_pcplus4_d = 32'd0;
                                    fd_valid_d   = 1'b0;
                                end
                            end
                            PIPE_STALL: begin
                                fd_instr_d   = fd_instr_q;
                                fd_pcplus4_d = fd_pcplus4_q;
                                fd_valid_d   = fd_valid_q;
                            end
                            default: begin
                                fd_instr_d   = 32'd0;
                                fd_pcplus4_d = 32'd0;
                                fd_valid_d   = 1'b0;
                            end
                        endcase
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = HALTED;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= RUN;
            pc_q          <= PC_INIT;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'd0;
            fd_instr_q    <= 32'd0;
            fd_pcplus4_q  <= 32'd0;
            fd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            fd_instr_q    <= fd_instr_d;
            fd_pcplus4_q  <= fd_pcplus4_d;
            fd_valid_q    <= fd_valid_d;
        end
    end

    assign imemREN          = (state_q == RUN);
    assign imemaddr         = pc_q;
    assign fd_instr         = fd_instr_q;
    assign fd_pcplus4       = fd_pcplus4_q;
    assign fd_valid         = fd_valid_q;
    assign redirect_pending = pend_valid_q;
    assign fsm_state        = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table for the documented scenarios,
// then randomized cycles checked against a behavioural model.

module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] INIT = 32'h0000_0100;
    localparam logic [31:0] JUNK_BR = 32'hB0B0_0000;
    localparam logic [31:0] JUNK_JR = 32'hC0C0_0000;
    localparam logic [31:0] JUNK_J  = 32'hD0D0_0000;

    logic         CLK;
    logic         RST;
    logic         ihit;
    logic [31:0]  imemload;
    logic         imemREN;
    logic [31:0]  imemaddr;
    logic         pc_wen;
    logic [1:0]   pcsrc;
    logic [31:0]  br_target;
    logic [31:0]  jr_target;
    logic [31:0]  j_target;
    pipe_state_t  fd_state;
    logic         halt;
    logic [31:0]  fd_instr;
    logic [31:0]  fd_pcplus4;
    logic         fd_valid;
    logic         redirect_pending;
    fetch_state_t fsm_state;

    fetch_stage #(.PC_INIT(INIT)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .pc_wen(pc_wen),
        .pcsrc(pcsrc), .br_target(br_target), .jr_target(jr_target),
        .j_target(j_target), .fd_state(fd_state), .halt(halt),
        .fd_instr(fd_instr), .fd_pcplus4(fd_pcplus4), .fd_valid(fd_valid),
        .redirect_pending(redirect_pending), .fsm_state(fsm_state)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model state
    logic [31:0] m_pc, m_pend_t, m_instr, m_p4;
    logic        m_pend_v, m_valid, m_halted;

    task automatic model_step();
        logic [31:0] old_p4;
        logic [31:0] tgt;
        logic        squash;
        old_p4 = m_pc + 32'd4;
        squash = 1'b0;
        tgt = (pcsrc == 2'd1) ? br_target : (pcsrc == 2'd2) ? jr_target : j_target;
        if (RST) begin
            m_pc = INIT; m_pend_v = 1'b0; m_instr = '0; m_p4 = '0;
            m_valid = 1'b0; m_halted = 1'b0;
        end else if (m_halted) begin
            // frozen
        end else if (halt) begin
            m_halted = 1'b1;
        end else begin
            if (pc_wen) begin
                if (pcsrc != 2'd0) m_pc = tgt;
                else if (m_pend_v) begin m_pc = m_pend_t; squash = 1'b1; end
                else m_pc = old_p4;
                m_pend_v = 1'b0;
            end else if (pcsrc != 2'd0) begin
                m_pend_v = 1'b1;
                m_pend_t = tgt;
            end
            if (squash || fd_state == PIPE_NOP || (fd_state == PIPE_ENABLE && !ihit)) begin
                m_instr = '0; m_p4 = '0; m_valid = 1'b0;
            end else if (fd_state == PIPE_ENABLE) begin
                m_instr = imemload; m_p4 = old_p4; m_valid = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic        rst, halt, wen;
        logic [1:0]  src;
        logic [31:0] tgt;
        pipe_state_t fs;
        logic        hit;
        logic [31:0] load;
        logic [31:0] e_addr, e_instr, e_p4;
        logic        e_valid, e_pend, e_ren;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic h, logic w, logic [1:0] s, logic [31:0] t,
                                pipe_state_t f, logic hi, logic [31:0] ld,
                                logic [31:0] ea, logic [31:0] ei, logic [31:0] ep,
                                logic ev, logic epd, logic er);
        vec_t v;
        v.rst = r; v.halt = h; v.wen = w; v.src = s; v.tgt = t; v.fs = f; v.hit = hi;
        v.load = ld; v.e_addr = ea; v.e_instr = ei; v.e_p4 = ep; v.e_valid = ev;
        v.e_pend = epd; v.e_ren = er;
        return v;
    endfunction

    task automatic apply_vec(input vec_t v);
        RST = v.rst; halt = v.halt; pc_wen = v.wen; pcsrc = v.src;
        br_target = JUNK_BR; jr_target = JUNK_JR; j_target = JUNK_J;
        if (v.src == 2'd1) br_target = v.tgt;
        if (v.src == 2'd2) jr_target = v.tgt;
        if (v.src == 2'd3) j_target  = v.tgt;
        fd_state = v.fs; ihit = v.hit; imemload = v.load;
    endtask

    initial begin
        RST = 1'b1; halt = 1'b0; pc_wen = 1'b0; pcsrc = 2'd0; ihit = 1'b0;
        imemload = '0; br_target = '0; jr_target = '0; j_target = '0;
        fd_state = PIPE_ENABLE;

        //             rst  halt wen  src  tgt           fs           hit  load       addr          instr       p4            v    pend ren
        vecs.push_back(mk(1, 0, 0, 0, 0,             PIPE_ENABLE, 1, 32'h1111,  INIT,         0,          0,            0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,             PIPE_ENABLE, 1, 32'h11,    32'h104,      32'h11,     32'h104,      1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,             PIPE_ENABLE, 1, 32'h22,    32'h108,      32'h22,     32'h108,      1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,             PIPE_ENABLE, 1, 32'h33,    32'h10C,      32'h33,     32'h10C,      1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 32'h200,       PIPE_NOP,    1, 32'h44,    32'h200,      0,          0,            0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 3, 32'h400,       PIPE_ENABLE, 1, 32'h55,    32'h200,      32'h55,     32'h204,      1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,             PIPE_ENABLE, 1, 32'h66,    32'h200,      32'h66,     32'h204,      1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,             PIPE_ENABLE, 1, 32'h77,    32'h400,      0,          0,            0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 2, 32'h300,       PIPE_ENABLE, 1, 32'h88,    32'h400,      32'h88,     32'h404,      1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 32'h500,       PIPE_STALL,  1, 32'h99,    32'h400,      32'h88,     32'h404,      1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,             PIPE_ENABLE, 1, 32'hAA,    32'h500,      0,          0,            0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 32'hFFFF_FFFC, PIPE_ENABLE, 1, 32'hBB,    32'hFFFF_FFFC,32'hBB,     32'h504,      1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,             PIPE_ENABLE, 1, 32'hCC,    32'h0,        32'hCC,     32'h0,        1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,             PIPE_STALL,  1, 32'hDD,    32'h0,        32'hCC,     32'h0,        1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 2, 32'h600,       PIPE_STALL,  1, 32'hEE,    32'h0,        32'hCC,     32'h0,        1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 3, 32'h700,       PIPE_ENABLE, 1, 32'hEF,    32'h0,        32'hCC,     32'h0,        1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h740,       PIPE_NOP,    1, 32'hF0,    32'h0,        32'hCC,     32'h0,        1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,             PIPE_ENABLE, 1, 32'hF1,    INIT,         0,          0,            0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 3, 32'h800,       PIPE_ENABLE, 1, 32'h12,    INIT,         32'h12,     32'h104,      1, 1, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0,             PIPE_ENABLE, 1, 32'h13,    INIT,         0,          0,            0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,             PIPE_ENABLE, 0, 32'h14,    32'h104,      0,          0,            0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(vecs[i]);
            step();
            check($sformatf("v%0d imemaddr", i), imemaddr, vecs[i].e_addr);
            check($sformatf("v%0d fd_instr", i), fd_instr, vecs[i].e_instr);
            check($sformatf("v%0d fd_pcplus4", i), fd_pcplus4, vecs[i].e_p4);
            check($sformatf("v%0d fd_valid", i), {31'd0, fd_valid}, {31'd0, vecs[i].e_valid});
            check($sformatf("v%0d redirect_pending", i), {31'd0, redirect_pending}, {31'd0, vecs[i].e_pend});
            check($sformatf("v%0d imemREN", i), {31'd0, imemREN}, {31'd0, vecs[i].e_ren});
        end

        // randomized run against the model; starts from a reset cycle
        RST = 1'b1; halt = 1'b0; pc_wen = 1'b0; pcsrc = 2'd0;
        m_pc = '0; m_pend_t = '0; m_pend_v = 1'b0; m_instr = '0; m_p4 = '0;
        m_valid = 1'b0; m_halted = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) begin
                RST       = m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
                halt      = ($urandom_range(0, 79) == 0);
                pc_wen    = ($urandom_range(0, 2) != 0);
                pcsrc     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
                br_target = {$urandom()} & 32'hFFFF_FFFC;
                jr_target = {$urandom()} & 32'hFFFF_FFFC;
                j_target  = {$urandom()} & 32'hFFFF_FFFC;
                fd_state  = pipe_state_t'($urandom_range(0, 2));
                ihit      = ($urandom_range(0, 3) != 0);
                imemload  = $urandom();
            end
            model_step();
            exp_q.push_back(m_pc);
            step();
            check("rnd imemaddr", imemaddr, exp_q.pop_front());
            check("rnd fd_instr", fd_instr, m_instr);
            check("rnd fd_pcplus4", fd_pcplus4, m_p4);
            check("rnd fd_valid", {31'd0, fd_valid}, {31'd0, m_valid});
            check("rnd redirect_pending", {31'd0, redirect_pending}, {31'd0, m_pend_v});
            check("rnd imemREN", {31'd0, imemREN}, {31'd0, !m_halted});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
